hazard_forward_unit: RTL

Parametrised data-hazard controller for the in-order EX/MEM/WB integer pipeline. It generalises the combinational two-source forwarding selector:
- any number of source operands and register-address width;
- an internal shadow of in-flight destinations;
- registered forwarding selects, including a WB write-through path;
- a counted load-use stall state machine sized to the data-memory latency.

It sits beside the ID/EX pipeline register and drives the EX-stage operand muxes and the front-end stall.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_forward_unit_fwd_src_select.sv | 40 ++++
 rtl/hazard_forward_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the hazard/forwarding unit
// Contents:
//   FWD_* : 2-bit EX operand mux select encodings
//   fsm_state_t : load-use stall FSM states
//   stage_t : shadow of one in-flight pipeline stage {valid, rd, we, ld}
package hazard_pkg;

  // Shadow rd is stored at a fixed width; narrower register addresses are
  // zero-extended into it so every configuration shares one struct.
  localparam int RD_MAX = 8;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              we;
    logic              ld;
  } stage_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_src_select.sv
// rtl/hazard_forward_unit_fwd_src_select.sv - per-source forwarding priority compare
// Ports:
//   used      in  source is actually read
//   src       in  source register address
//   ex_stage  in  EX shadow;  mem_stage in MEM shadow;  wb_stage in WB shadow
//   sel       out forwarding select (youngest producer wins)
//   load_use  out source depends on a load still in EX
module fwd_src_select
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              used,
  input  logic [REG_AW-1:0] src,
  input  stage_t            ex_stage,
  input  stage_t            mem_stage,
  input  stage_t            wb_stage,
  output logic [1:0]        sel,
  output logic              load_use
);

  function automatic logic writes(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.we && (s.rd == RD_MAX'(r)) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  always_comb begin
    sel      = FWD_RF;
    load_use = 1'b0;
    if (used) begin
      // A load in EX has no data yet: it raises load-use and is skipped for
      // forwarding, so the stall machinery supplies the bubble(s).
      if (writes(ex_stage, src) && ex_stage.ld) load_use = 1'b1;
      if (writes(ex_stage, src) && !ex_stage.ld) sel = FWD_EXMEM;
      else if (writes(mem_stage, src))           sel = FWD_MEMWB;
      else if (writes(wb_stage, src))            sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - data-hazard controller: forwarding selects and load-use stall
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hold            global freeze; flush kills the ID instruction
//   id_valid/rd/we/ld, id_src, id_src_used   ID-stage instruction fields
//   stall           combinational front-end stall
//   ex_fwd_sel      registered 2-bit select per source (source k at [2k+1:2k])
//   ex_valid        registered; EX holds a real instruction
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int NSRC     = 2,
  parameter int LD_STALL = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_we,
  input  logic                   id_ld,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  output logic                   stall,
  output logic [2*NSRC-1:0]      ex_fwd_sel,
  output logic                   ex_valid
);

  stage_t ex_q, mem_q, wb_q, id_stage;
  fsm_state_t state, state_next;
  logic cnt, cnt_next;
  logic [2*NSRC-1:0] sel_comb;
  logic [NSRC-1:0] lu_vec;
  logic load_use;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_src_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_sel (
      .used      (id_src_used[k]),
      .src       (id_src[k*REG_AW +: REG_AW]),
      .ex_stage  (ex_q),
      .mem_stage (mem_q),
      .wb_stage  (wb_q),
      .sel       (sel_comb[2*k +: 2]),
      .load_use  (lu_vec[k])
    );
  end

  assign load_use = |lu_vec;
  assign ex_valid = ex_q.valid;

  always_comb begin
    id_stage.valid = id_valid;
    id_stage.rd    = RD_MAX'(id_rd);
    id_stage.we    = id_we;
    id_stage.ld    = id_ld;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = id_valid & load_use;
        // The detect cycle is the first bubble; a two-cycle memory needs one more.
        if (stall && !hold && !flush && (LD_STALL == 2)) begin
          state_next = ST_WAIT;
          cnt_next   = 1'b1;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (!hold) begin
          cnt_next = cnt - 1'b1;
          if (cnt_next == 1'b0) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Update precedence: flush > hold > stall > normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      ex_fwd_sel <= '0;
    end else if (flush) begin
      ex_q       <= '0;
      ex_fwd_sel <= '0;
      if (!hold) begin
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end else if (!hold) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall) begin
        ex_q       <= '0;
        ex_fwd_sel <= '0;
      end else begin
        ex_q       <= id_stage;
        ex_fwd_sel <= sel_comb;
      end
    end
  end

endmodule
